// File: rtl/seg_display_scanner.sv
// seg_display_scanner
//
// Multiplexed seven-segment display controller. A binary value is converted
// to BCD by a sequential shift-add-3 (double-dabble) engine. The result is
// then time-multiplexed across N_DIG digits that share one cathode bus.
//
// Parameters:
//   N_DIG       number of digits (1..8)
//   BIN_W       width of the binary input (4..27)
//   REFRESH_DIV clock cycles each digit is held (>= 1)
//
// Ports:
//   CLK       system clock, rising edge
//   Reset     synchronous, active-high reset
//   Bin       unsigned value to display
//   Load      request a conversion of Bin (ignored while Busy)
//   DP        decimal point enable per digit (bit 0 = least significant)
//   Blank_Lz  1 = blank leading zeros
//   Enable    0 = all digits dark, scan frozen
//   Busy      conversion in progress
//   Ovf       last committed value did not fit in N_DIG digits
//   An        anodes, active-low one-hot
//   Cat       cathodes {dp,g,f,e,d,c,b,a}, active-low

module seg_display_scanner #(
   parameter int N_DIG       = 4,
   parameter int BIN_W       = 14,
   parameter int REFRESH_DIV = 50000
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [BIN_W-1:0] Bin,
   input  logic             Load,
   input  logic [N_DIG-1:0] DP,
   input  logic             Blank_Lz,
   input  logic             Enable,
   output logic             Busy,
   output logic             Ovf,
   output logic [N_DIG-1:0] An,
   output logic [7:0]       Cat
);

   // One nibble more than the decimal digit count of 2^BIN_W-1, so the
   // accumulator can never truncate during conversion.
   function automatic int bcd_nibbles(input int w);
      longint v;
      int     n;
      v = (longint'(1) << w) - 1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (v > 0) begin
            v = v / 10;
            n++;
         end
      end
      return n + 1;
   endfunction

   function automatic longint max_shown(input int n);
      longint p;
      p = 1;
      for (int k = 0; k < n; k++) p = p * 10;
      return p - 1;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   localparam int          BCD_N     = bcd_nibbles(BIN_W);
   // The accumulator is at least N_DIG nibbles wide so the commit slice always exists.
   localparam int          ACC_N     = (BCD_N > N_DIG) ? BCD_N : N_DIG;
   localparam int          CNT_W     = $clog2(BIN_W + 1);
   localparam int          PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int          IDX_W     = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [63:0] MAX_SHOWN = 64'(max_shown(N_DIG));

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

   conv_state_t            state, state_next;
   logic [BIN_W-1:0]       bin_sr;
   logic [BIN_W-1:0]       cap_bin;
   logic [ACC_N*4-1:0]     bcd;
   logic [ACC_N*4-1:0]     bcd_adj;
   logic [CNT_W-1:0]       cnt;
   logic [N_DIG*4-1:0]     disp;
   logic                   ovf_q;
   logic [PRE_W-1:0]       presc;
   logic [IDX_W-1:0]       idx;
   logic [N_DIG-1:0]       lz;
   logic [N_DIG-1:0]       an_next;
   logic [7:0]             cat_next;
   logic [3:0]             sel_nib;
   logic                   sel_dp;
   logic                   sel_lz;
   logic [6:0]             seg;

   // Converter next-state logic.
   always_comb begin
      state_next = state;
      Busy       = (state != IDLE);
      case (state)
         IDLE:    if (Load) state_next = SHIFT;
         SHIFT:   if (cnt == CNT_W'(1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Add-3 correction applied to every nibble before each shift.
   always_comb begin
      bcd_adj = bcd;
      for (int n = 0; n < ACC_N; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
   end

   // Converter datapath. The display register only changes in COMMIT, so
   // the visible digits update atomically.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= IDLE;
         bin_sr  <= '0;
         cap_bin <= '0;
         bcd     <= '0;
         cnt     <= '0;
         disp    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (Load) begin
                  bin_sr  <= Bin;
                  cap_bin <= Bin;
                  bcd     <= '0;
                  cnt     <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               bcd    <= {bcd_adj[ACC_N*4-2:0], bin_sr[BIN_W-1]};
               bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
               cnt    <= cnt - CNT_W'(1);
            end
            COMMIT: begin
               disp  <= bcd[N_DIG*4-1:0];
               ovf_q <= ({{(64-BIN_W){1'b0}}, cap_bin} > MAX_SHOWN);
            end
            default: ;
         endcase
      end
   end

   assign Ovf = ovf_q;

   // Scan prescaler and digit index; both freeze while the display is disabled.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         presc <= '0;
         idx   <= '0;
      end else if (Enable) begin
         if (presc == PRE_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(N_DIG - 1)) ? '0 : idx + IDX_W'(1);
         end else begin
            presc <= presc + PRE_W'(1);
         end
      end
   end

   // lz[i] is set when nibble i and every nibble above it are zero.
   always_comb begin
      lz = '0;
      for (int i = N_DIG - 1; i >= 0; i--) begin
         if (i == N_DIG - 1) lz[i] = (disp[i*4 +: 4] == 4'd0);
         else                lz[i] = lz[i+1] && (disp[i*4 +: 4] == 4'd0);
      end
   end

   // Select the current digit and build the next anode/cathode pattern.
   always_comb begin
      sel_nib  = 4'd0;
      sel_dp   = 1'b0;
      sel_lz   = 1'b0;
      an_next  = '1;
      cat_next = 8'hFF;
      seg      = 7'h7F;
      for (int i = 0; i < N_DIG; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_nib = disp[i*4 +: 4];
            sel_dp  = DP[i];
            sel_lz  = lz[i] && (i != 0);
         end
      end
      if (ovf_q)                  seg = 7'b0111111;
      else if (Blank_Lz && sel_lz) seg = 7'h7F;
      else                         seg = seg_decode(sel_nib);
      if (Enable) begin
         for (int i = 0; i < N_DIG; i++) begin
            if (idx == IDX_W'(i)) an_next[i] = 1'b0;
         end
         cat_next = {~sel_dp, seg};
      end
   end

   // Registered pin drivers.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         An  <= '1;
         Cat <= 8'hFF;
      end else begin
         An  <= an_next;
         Cat <= cat_next;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner
//
// Directed bench for seg_display_scanner with N_DIG=4, BIN_W=14,
// REFRESH_DIV=4. Expected cathode patterns are computed from a decimal
// model when a value is loaded, queued, and compared as each digit
// comes up on the scan.

module tb_seg_display_scanner;

   localparam int N_DIG = 4;
   localparam int BIN_W = 14;
   localparam int RD    = 4;

   logic             CLK = 1'b0;
   logic             Reset;
   logic [BIN_W-1:0] Bin;
   logic             Load;
   logic [N_DIG-1:0] DP;
   logic             Blank_Lz;
   logic             Enable;
   logic             Busy;
   logic             Ovf;
   logic [N_DIG-1:0] An;
   logic [7:0]       Cat;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         dig;
      logic [7:0] cat;
   } exp_t;

   exp_t sb[$];

   seg_display_scanner #(
      .N_DIG      (N_DIG),
      .BIN_W      (BIN_W),
      .REFRESH_DIV(RD)
   ) dut (
      .CLK     (CLK),
      .Reset   (Reset),
      .Bin     (Bin),
      .Load    (Load),
      .DP      (DP),
      .Blank_Lz(Blank_Lz),
      .Enable  (Enable),
      .Busy    (Busy),
      .Ovf     (Ovf),
      .An      (An),
      .Cat     (Cat)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] segOf(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [7:0] modelCat(input int val, input int i, input logic [3:0] dp, input logic blank);
      int         p;
      logic [6:0] s;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      if (val > 9999)                          s = 7'b0111111;
      else if (blank && i != 0 && val / p == 0) s = 7'h7F;
      else                                     s = segOf((val / p) % 10);
      return {~dp[i], s};
   endfunction

   task automatic pushExpected(input int val);
      for (int i = 0; i < N_DIG; i++) sb.push_back('{i, modelCat(val, i, DP, Blank_Lz)});
   endtask

   // Drive one Load pulse; returns just after the accepting edge.
   task automatic applyStimulus(input int val);
      Bin  = BIN_W'(val);
      Load = 1'b1;
      tick();
      Load = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checkValue({tag, "_idle"}, 32'(Busy), 32'd0);
      tick();
   endtask

   task automatic findDigit(input int i, output logic [7:0] cat, output logic found);
      found = 1'b0;
      cat   = 8'hxx;
      for (int n = 0; n < N_DIG * RD + 4 && !found; n++) begin
         if (An === 4'(~(4'b0001 << i))) begin
            found = 1'b1;
            cat   = Cat;
         end else begin
            tick();
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      exp_t       e;
      logic [7:0] cat;
      logic       found;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         findDigit(e.dig, cat, found);
         checkValue($sformatf("%s_found%0d", tag, e.dig), 32'(found), 32'd1);
         if (found) checkValue($sformatf("%s_d%0d", tag, e.dig), 32'(cat), 32'(e.cat));
      end
   endtask

   initial begin
      logic [7:0] c;
      logic       f;

      Reset    = 1'b1;
      Load     = 1'b0;
      Bin      = '0;
      DP       = '0;
      Blank_Lz = 1'b0;
      Enable   = 1'b1;
      tick();
      tick();
      tick();
      checkValue("reset_an", 32'(An), 32'h0F);
      checkValue("reset_cat", 32'(Cat), 32'hFF);
      checkValue("reset_busy", 32'(Busy), 32'd0);
      checkValue("reset_ovf", 32'(Ovf), 32'd0);

      // Scan after reset: digit 0 shows "0", each digit held RD cycles.
      Reset = 1'b0;
      tick();
      checkValue("first_cat", 32'(Cat), 32'hC0);
      checkValue("scan_an0", 32'(An), 32'(4'b1110));
      for (int j = 1; j < 16; j++) begin
         tick();
         checkValue($sformatf("scan_an%0d", j), 32'(An), 32'(4'(~(4'b0001 << (j / RD)))));
      end

      // Busy window for a normal conversion.
      applyStimulus(1234);
      pushExpected(1234);
      checkValue("busy_k", 32'(Busy), 32'd1);
      for (int j = 1; j <= BIN_W; j++) begin
         tick();
         checkValue($sformatf("busy_k%0d", j), 32'(Busy), 32'd1);
      end
      tick();
      checkValue("busy_fall", 32'(Busy), 32'd0);
      checkValue("ovf_1234", 32'(Ovf), 32'd0);
      tick();
      checkOutput("bin1234");

      // Leading-zero blanking with a decimal point on a blanked digit.
      Blank_Lz = 1'b1;
      DP       = 4'b0100;
      applyStimulus(7);
      pushExpected(7);
      waitIdle("lz7");
      checkOutput("lz7");
      Blank_Lz = 1'b0;
      pushExpected(7);
      tick();
      checkOutput("nolz7");
      DP = 4'b0000;

      // Overflow boundary.
      applyStimulus(10000);
      pushExpected(10000);
      waitIdle("ovf");
      checkValue("ovf_set", 32'(Ovf), 32'd1);
      checkOutput("ovf10000");
      applyStimulus(9999);
      pushExpected(9999);
      waitIdle("max");
      checkValue("ovf_clr", 32'(Ovf), 32'd0);
      checkOutput("bin9999");

      // Load while busy is dropped.
      applyStimulus(1234);
      tick();
      tick();
      Bin  = BIN_W'(5678);
      Load = 1'b1;
      tick();
      Load = 1'b0;
      checkValue("ign_busy", 32'(Busy), 32'd1);
      pushExpected(1234);
      waitIdle("ign");
      tick();
      tick();
      checkValue("ign_no_requeue", 32'(Busy), 32'd0);
      checkOutput("ignore");

      // Reset in the middle of a conversion.
      applyStimulus(4321);
      tick();
      tick();
      tick();
      tick();
      Reset = 1'b1;
      tick();
      checkValue("abort_busy", 32'(Busy), 32'd0);
      checkValue("abort_an", 32'(An), 32'h0F);
      checkValue("abort_cat", 32'(Cat), 32'hFF);
      Reset = 1'b0;
      for (int j = 0; j < 20; j++) tick();
      checkValue("abort_no_commit", 32'(Busy), 32'd0);
      checkValue("abort_ovf", 32'(Ovf), 32'd0);
      pushExpected(0);
      checkOutput("abort");

      // Enable freeze at index 2 and resume with the held prescaler.
      findDigit(1, c, f);
      checkValue("en_find1", 32'(f), 32'd1);
      findDigit(2, c, f);
      checkValue("en_find2", 32'(f), 32'd1);
      Enable = 1'b0;
      tick();
      checkValue("dis_an", 32'(An), 32'h0F);
      checkValue("dis_cat", 32'(Cat), 32'hFF);
      for (int j = 0; j < 4; j++) tick();
      checkValue("dis_hold_an", 32'(An), 32'h0F);
      Enable = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         checkValue($sformatf("resume_an%0d", j), 32'(An), 32'(4'b1011));
      end
      tick();
      checkValue("resume_next", 32'(An), 32'(4'b0111));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
